vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates raster timing for the VGA output path. Runs on the 65 MHz pixel clock from PLL_1, giving 1024x768@60 by default.
- Drives pixel coordinates and data-enable to the digital-clock display renderer.
- Drives sync and blank signals that are delayed to line up with the renderer's RGB latency, so HSYNC, VSYNC, BLANK_N and RGB reach the DAC on the same cycle.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- PIPE_DLY, 2, renderer latency in clocks; must be 0..15

Ports:
- clk  in  1  pixel clock (65 MHz)
- rst_N  in  1  asynchronous active-low reset
- en  in  1  timing enable; low = raster held idle
- pix_x  out  11  current pixel column, 0..H_ACTIVE-1
- pix_y  out  10  current pixel row, 0..V_ACTIVE-1
- pix_de  out  1  pix_x/pix_y are in the visible area
- line_start  out  1  one-cycle pulse at h_cnt=0 of every line
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- frame_cnt  out  8  frame counter, wraps at 255->0
- VGA_HSYNC  out  1  horizontal sync, delayed by PIPE_DLY
- VGA_VSYNC  out  1  vertical sync, delayed by PIPE_DLY
- VGA_BLANK_N  out  1  high in the visible area, delayed by PIPE_DLY
- VGA_SYNC_N  out  1  constant 0

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H parameters (1344).
  - V_TOTAL = sum of the four V parameters (806).
- Internal counters:
  - h_cnt is 11 bits and v_cnt is 10 bits; both reset to 0.
  - Each clock with en=1, h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with h_cnt wrap, v_cnt wraps to 0 and frame_cnt increments (modulo 256).
- Regions:
  - Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Hsync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Vsync when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Vsync is line-aligned: it changes only at h_cnt = 0.
- Stage 1 (latency 1 clock from the counters), all registered:
  - pix_de is the active region.
  - pix_x = h_cnt and pix_y = v_cnt when active; both are forced to 0 when not active.
  - line_start and frame_start are registered pulses.
- Stage 2:
  - Raw hsync, vsync and de from stage 1 pass through a PIPE_DLY-deep shift register.
  - Outputs: VGA_HSYNC = hsync XNOR H_POL, VGA_VSYNC = vsync XNOR V_POL, VGA_BLANK_N = de.
  - PIPE_DLY=0 means a direct pass of the stage-1 values.
- Reset values (all outputs):
  - pix_x=0, pix_y=0, pix_de=0, line_start=0, frame_start=0, frame_cnt=0.
  - VGA_HSYNC = ~H_POL and VGA_VSYNC = ~V_POL (inactive level).
  - VGA_BLANK_N=0; delay-line contents are the inactive levels.
- en=0:
  - h_cnt and v_cnt are cleared synchronously to 0.
  - Stage 1 and the delay line load inactive values (de=0, syncs inactive, pulses 0).
  - frame_cnt holds its value.
- en rising: the first frame_start appears 1 clock after the first enabled cycle, and counting starts at (0,0).
- Reset mid-frame: all state returns asynchronously to reset values. Counting restarts at (0,0) on the first clock after rst_N is released with en=1. No partial-line glitch on the sync outputs beyond an inactive level.
- Simultaneous h and v wrap: frame_start and line_start pulse on the same cycle.

Decomposition:
- Shared package vga_timing_pkg holds:
  - Localparam sets for 1024x768@60 (values above).
  - Localparam sets for 640x480@60: 640/16/96/48, 480/10/2/33, negative polarity.
  - H_TOTAL/V_TOTAL computation functions.
- One sub-module, vga_delay_line: parameterised WIDTH and DEPTH shift register with async active-low reset and a reset value input. Instantiated once, WIDTH=3, DEPTH=PIPE_DLY.

Test Plan:
- Reset then en=1, default params -> first frame_start 1 clock after enable; line_start period exactly 1344 clocks; frame_start period exactly 1083264 clocks.
- Hsync timing, PIPE_DLY=2 -> VGA_HSYNC low for exactly 136 clocks, falling 1048+1+2 clocks after line_start's source cycle; VGA_BLANK_N high for 1024 clocks per active line.
- Vsync timing -> VGA_VSYNC low for 6 lines (8064 clocks), starting at v_cnt=771, edges coincident with a line start; VGA_BLANK_N never high for v_cnt >= 768.
- Coordinates -> pix_x runs 0..1023 with pix_de=1 and is 0 when pix_de=0; pix_y=767 on the last active line; frame_cnt goes 255->0 after 256 frames.
- en dropped mid-line at h_cnt=500, v_cnt=300, then re-raised -> outputs inactive within 1+PIPE_DLY clocks; frame_cnt held; restart at (0,0) with frame_start pulse.
- rst_N asserted mid-frame -> all outputs immediately at reset values (HSYNC=1, VSYNC=1, BLANK_N=0, SYNC_N=0); normal timing resumes from (0,0) after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, the sync bundle type and total-length helpers.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a; the raster free-runs on the pixel clock.
package vga_timing_pkg;

   // Counter widths shared by the generator and its consumers
   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;
   localparam int FRAME_W = 8;

   // 1024x768@60 on a 65 MHz pixel clock
   localparam int XGA_H_ACTIVE = 1024;
   localparam int XGA_H_FP     = 24;
   localparam int XGA_H_SYNC   = 136;
   localparam int XGA_H_BP     = 160;
   localparam int XGA_V_ACTIVE = 768;
   localparam int XGA_V_FP     = 3;
   localparam int XGA_V_SYNC   = 6;
   localparam int XGA_V_BP     = 29;
   localparam logic XGA_H_POL  = 1'b0;
   localparam logic XGA_V_POL  = 1'b0;

   // 640x480@60 on a 25.175 MHz pixel clock
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam logic VGA_H_POL  = 1'b0;
   localparam logic VGA_V_POL  = 1'b0;

   // Raw (active-high) sync/enable bundle carried through the renderer-matching delay
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } sync_t;

   localparam int SYNC_W = $bits(sync_t);

   // Idle bundle: no sync asserted, outside the visible area
   localparam sync_t SYNC_IDLE = '{hsync: 1'b0, vsync: 1'b0, de: 1'b0};

   // Total period of one axis in counts (pixels per line or lines per frame)
   function automatic int calc_total(input int active, input int fp,
                                     input int sw, input int bp);
      return active + fp + sw + bp;
   endfunction

   function automatic int h_total_xga();
      return calc_total(XGA_H_ACTIVE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
   endfunction

   function automatic int v_total_xga();
      return calc_total(XGA_V_ACTIVE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that aligns sync/blank with the renderer's RGB pipeline.
// Latency: DEPTH clocks (DEPTH=0 is a combinational pass-through).
// Backpressure: none; clr reloads every stage with rst_val on the next clock.
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift one position per clock; reset and clear flush the whole line to rst_val
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= rst_val;
               end
            end else if (clr) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= rst_val;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates for the renderer plus DAC-aligned sync/blank.
// Latency: coordinates/pulses 1 clock after the counters; syncs/blank 1+PIPE_DLY clocks.
// Backpressure: none; en low parks the raster at (0,0) with all outputs inactive.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = XGA_H_ACTIVE,
   parameter int   H_FP     = XGA_H_FP,
   parameter int   H_SYNC   = XGA_H_SYNC,
   parameter int   H_BP     = XGA_H_BP,
   parameter int   V_ACTIVE = XGA_V_ACTIVE,
   parameter int   V_FP     = XGA_V_FP,
   parameter int   V_SYNC   = XGA_V_SYNC,
   parameter int   V_BP     = XGA_V_BP,
   parameter logic H_POL    = XGA_H_POL,
   parameter logic V_POL    = XGA_V_POL,
   // Renderer latency in clocks, 0..15
   parameter int   PIPE_DLY = 2
) (
   input  logic               clk,
   input  logic               rst_N,
   input  logic               en,
   output logic [H_CNT_W-1:0] pix_x,
   output logic [V_CNT_W-1:0] pix_y,
   output logic               pix_de,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               VGA_HSYNC,
   output logic               VGA_VSYNC,
   output logic               VGA_BLANK_N,
   output logic               VGA_SYNC_N
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // Region boundaries sized to the counters so comparisons stay width-matched
   localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               h_wrap;
   logic               v_wrap;
   logic               active;
   logic               in_hs;
   logic               in_vs;
   sync_t              s1_sync;
   sync_t              dly_sync;

   // Wrap conditions and region decode from the raw counters
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      in_hs  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      // v_cnt only moves on an h wrap, so vsync is inherently line-aligned
      in_vs  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   end

   // Horizontal/vertical raster counters; disabled raster sits at (0,0)
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + V_CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + H_CNT_W'(1);
      end
   end

   // Frame counter advances on the last pixel of the frame and holds while disabled
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         frame_cnt <= '0;
      end else if (en && h_wrap && v_wrap) begin
         frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

   // Stage 1: registered coordinates, pulses and raw sync bundle
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         pix_x       <= '0;
         pix_y       <= '0;
         pix_de      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         s1_sync     <= SYNC_IDLE;
      end else if (!en) begin
         pix_x       <= '0;
         pix_y       <= '0;
         pix_de      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         s1_sync     <= SYNC_IDLE;
      end else begin
         pix_x       <= active ? h_cnt : '0;
         pix_y       <= active ? v_cnt : '0;
         pix_de      <= active;
         line_start  <= (h_cnt == '0);
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         s1_sync     <= '{hsync: in_hs, vsync: in_vs, de: active};
      end
   end

   // Stage 2: match the renderer's RGB latency so everything lands at the DAC together
   vga_delay_line #(
      .WIDTH (SYNC_W),
      .DEPTH (PIPE_DLY)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_N),
      .clr     (~en),
      .rst_val (SYNC_IDLE),
      .din     (s1_sync),
      .dout    (dly_sync)
   );

   // Polarity is applied after the delay so the delay line only ever holds active-high flags
   assign VGA_HSYNC   = dly_sync.hsync ~^ H_POL;
   assign VGA_VSYNC   = dly_sync.vsync ~^ V_POL;
   assign VGA_BLANK_N = dly_sync.de;
   assign VGA_SYNC_N  = 1'b0;

endmodule
